// File: rtl/nioshello_mem_tester.sv
// Memory self-test master for the data memory's second Avalon-MM slave port.
// On an accepted start it writes seed+i to word base+i for i = 0..count-1.
// It then reads the same range back, one read per cycle, and checks each word
// against the pattern it wrote.
//
// State table:
//   IDLE  | waiting for start; parameters are latched here
//   WRITE | bus carries write number idx
//   READ  | bus carries read number idx; its compare runs one cycle later
//   DRAIN | bus quiet; the compare for the last read runs here
//   DONE  | done pulse; pass/err_count/first_err_addr hold the final result
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   start               one-cycle request, sampled in IDLE only
//   base, count, seed   run parameters, sampled together with start
//   busy, done, pass    run status (all registered)
//   err_count           number of mismatching words in the last run
//   first_err_addr      address of the first mismatch (0 if none)
//   m_*                 Avalon-MM master: fixed read latency 1, no waitrequest
module nioshello_mem_tester #(
  parameter int ADDR_WIDTH = 13,
  parameter int CNT_WIDTH  = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [CNT_WIDTH-1:0]  count,
  input  logic [31:0]           seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [ADDR_WIDTH-1:0] m_address,
  output logic [3:0]            m_byteenable,
  output logic                  m_chipselect,
  output logic                  m_write,
  output logic [31:0]           m_writedata,
  input  logic [31:0]           m_readdata
);

  typedef enum logic [2:0] {ST_IDLE, ST_WRITE, ST_READ, ST_DRAIN, ST_DONE} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                state, state_n;
  logic [CNT_WIDTH-1:0]  idx, idx_n, cnt_q, cnt_n, idx_inc;
  logic [ADDR_WIDTH-1:0] base_q, base_n;
  logic [31:0]           seed_q, seed_n;
  logic                  chk_vld, chk_vld_n;
  logic [31:0]           chk_exp, chk_exp_n;
  logic [ADDR_WIDTH-1:0] chk_addr, chk_addr_n;
  logic                  busy_n, done_n, pass_n, cs_n, we_n;
  logic [CNT_WIDTH-1:0]  err_n, err_upd;
  logic [ADDR_WIDTH-1:0] first_n, first_upd, addr_n;
  logic [31:0]           wd_n;
  logic                  last;

  assign idx_inc = idx + CNT_ONE;
  assign last    = (idx == cnt_q - CNT_ONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      idx            <= '0;
      cnt_q          <= '0;
      base_q         <= '0;
      seed_q         <= '0;
      chk_vld        <= 1'b0;
      chk_exp        <= '0;
      chk_addr       <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      m_address      <= '0;
      m_byteenable   <= 4'h0;
      m_chipselect   <= 1'b0;
      m_write        <= 1'b0;
      m_writedata    <= '0;
    end else begin
      state          <= state_n;
      idx            <= idx_n;
      cnt_q          <= cnt_n;
      base_q         <= base_n;
      seed_q         <= seed_n;
      chk_vld        <= chk_vld_n;
      chk_exp        <= chk_exp_n;
      chk_addr       <= chk_addr_n;
      busy           <= busy_n;
      done           <= done_n;
      pass           <= pass_n;
      err_count      <= err_n;
      first_err_addr <= first_n;
      m_address      <= addr_n;
      m_byteenable   <= cs_n ? 4'hF : 4'h0;
      m_chipselect   <= cs_n;
      m_write        <= we_n;
      m_writedata    <= wd_n;
    end
  end

  always_comb begin
    // Check stage: read data for the read issued last cycle is on m_readdata now.
    err_upd   = err_count;
    first_upd = first_err_addr;
    if (chk_vld && (m_readdata != chk_exp)) begin
      err_upd = err_count + CNT_ONE;
      if (err_count == '0) first_upd = chk_addr;
    end

    state_n    = state;
    idx_n      = idx;
    cnt_n      = cnt_q;
    base_n     = base_q;
    seed_n     = seed_q;
    chk_vld_n  = 1'b0;
    chk_exp_n  = chk_exp;
    chk_addr_n = chk_addr;
    busy_n     = busy;
    done_n     = 1'b0;
    pass_n     = pass;
    err_n      = err_upd;
    first_n    = first_upd;
    cs_n       = 1'b0;
    we_n       = 1'b0;
    addr_n     = m_address;
    wd_n       = m_writedata;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          base_n  = base;
          cnt_n   = count;
          seed_n  = seed;
          idx_n   = '0;
          err_n   = '0;
          first_n = '0;
          pass_n  = 1'b0;
          if (count == '0) begin
            state_n = ST_DONE;
            done_n  = 1'b1;
            pass_n  = 1'b1;
          end else begin
            state_n = ST_WRITE;
            busy_n  = 1'b1;
            cs_n    = 1'b1;
            we_n    = 1'b1;
            addr_n  = base;
            wd_n    = seed;
          end
        end
      end
      ST_WRITE: begin
        cs_n = 1'b1;
        if (last) begin
          // Straight into the first read with no gap on the bus.
          state_n = ST_READ;
          idx_n   = '0;
          addr_n  = base_q;
        end else begin
          idx_n  = idx_inc;
          we_n   = 1'b1;
          addr_n = base_q + idx_inc[ADDR_WIDTH-1:0];
          wd_n   = seed_q + 32'(idx_inc);
        end
      end
      ST_READ: begin
        chk_vld_n  = 1'b1;
        chk_exp_n  = seed_q + 32'(idx);
        chk_addr_n = m_address;
        if (last) begin
          state_n = ST_DRAIN;
        end else begin
          idx_n  = idx_inc;
          cs_n   = 1'b1;
          addr_n = base_q + idx_inc[ADDR_WIDTH-1:0];
        end
      end
      ST_DRAIN: begin
        // pass must include the final compare, which completes this cycle.
        state_n = ST_DONE;
        done_n  = 1'b1;
        busy_n  = 1'b0;
        pass_n  = (err_upd == '0);
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/nioshello_mem_tester.md
# niosHello_mem_tester

Avalon-MM master that exercises the on-chip data memory from the opposite end of its slave port. On a start pulse it writes an incrementing 32-bit pattern over a programmable word range, then reads the range back with a fully pipelined one-read-per-cycle stream and checks every word. It sits beside the Nios II data master on the memory's second slave port and is used for bring-up and power-on self-test.

## Interface
- ADDR_WIDTH, 13: word-address width of the target memory (8192 words).
- CNT_WIDTH, 14: width of count and error counter; must satisfy 2^CNT_WIDTH > 2^ADDR_WIDTH.
- clk  in  1  single system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base  in  ADDR_WIDTH  first word address; sampled with start.
- count  in  CNT_WIDTH  number of words, 0..2^ADDR_WIDTH; sampled with start.
- seed  in  32  pattern seed; sampled with start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse at test end.
- pass  out  1  1 when err_count==0; valid from done, held until next accepted start.
- err_count  out  CNT_WIDTH  mismatching words in the last run.
- first_err_addr  out  ADDR_WIDTH  address of the first mismatch; 0 if none.
- m_address  out  ADDR_WIDTH  master word address.
- m_byteenable  out  4  always 4'hF while chipselect is high, 4'h0 otherwise.
- m_chipselect  out  1  transfer valid.
- m_write  out  1  1 = write, 0 = read (only meaningful with chipselect).
- m_writedata  out  32  write data.
- m_readdata  in  32  read data, valid exactly one cycle after a read is issued (fixed read latency 1, no waitrequest).

## Operation
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE: start=1 latches base/count/seed, clears err_count, first_err_addr, pass; count==0 -> DONE, else -> WRITE with index i=0.
- WRITE: each cycle issue write: address=(base+i) mod 2^ADDR_WIDTH, writedata=(seed+i) mod 2^32; i==count-1 -> READ with i=0, else i+1.
- READ: each cycle issue read of (base+i); a delayed-valid flag and expected value (seed+i) and address pipeline one stage; i==count-1 -> DRAIN.
- Check stage: whenever the delayed-valid flag is set, compare m_readdata to expected; on mismatch err_count+1 and, if err_count was 0, capture first_err_addr.
- DRAIN: no transfer; final compare completes. -> DONE.
- DONE: done=1, busy=0, pass=(err_count==0) (including the final compare). -> IDLE.
- Address wraps modulo 2^ADDR_WIDTH (base=8190,count=4 touches 8190,8191,0,1); pattern wraps modulo 2^32.
- start while not IDLE is ignored; start in the DONE cycle is ignored.
- err_count cannot overflow (max count < 2^CNT_WIDTH).

## Timing
- All outputs registered. Reset values: busy=0, done=0, pass=0, err_count=0, first_err_addr=0, m_chipselect=0, m_write=0, m_address=0, m_writedata=0, m_byteenable=0.
- start sampled at edge E0; first write drives bus in cycle 1; writes cycles 1..N; reads cycles N+1..2N; DRAIN cycle 2N+1; done high in cycle 2N+2. Total start-to-done latency 2N+2 cycles; count=0 gives done in cycle 1 with pass=1.
- No idle cycles between consecutive transfers or between last write and first read; a read of an address written earlier in the same run returns the new data.
- Reset mid-run: all outputs return to reset values asynchronously, m_chipselect drops immediately; state IDLE; the partial run reports nothing.

## Test plan
- base=0, count=4, seed=32'h1000_0000, ideal memory -> writes 0x10000000..0x10000003 at 0..3 in cycles 1-4, reads cycles 5-8, done in cycle 10, pass=1, err_count=0.
- base=8190, count=4, seed=32'hFFFF_FFFE -> addresses 8190,8191,0,1 with data FFFFFFFE,FFFFFFFF,0,1; pass=1.
- Memory model corrupts read of address 5 and 7 (bit 0 flipped), base=0, count=16 -> err_count=2, first_err_addr=5, pass=0, done in cycle 34.
- count=0 -> no chipselect ever, done in cycle 1, pass=1; count=8192, base=100 -> done in cycle 16386, every address written exactly once.
- start pulsed again during WRITE and in DONE cycle -> ignored; latched parameters and timing unchanged.
- reset asserted in READ cycle -> chipselect 0 same cycle, busy=0, no done; subsequent start runs a clean test to pass=1.
